// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the {instr, pc_plus_one} entry carried to IF/ID, and the PC increment
// helper. Imported by fetch_unit and fetch_skid_buf.
package fetch_pkg;

  localparam int PC_W = 32;

  // Bubble presented to IF/ID whenever no real instruction is available.
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STALL,
    S_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_plus_one;
  } fetch_entry_t;

  // Word-address increment; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding buffer for a fetched {instr, pc_plus_one} that came back
// from memory while the IF/ID output register was full and stalled.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   push      - capture din (ignored when flush is asserted)
//   pop       - release the held entry
//   flush     - discard any held entry; wins over push
//   din       - entry to capture
//   dout      - held entry (meaningful while full=1)
//   full      - an entry is held
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  logic         full_q, full_d;
  fetch_entry_t data_q, data_d;

  // Next-state for the single entry. A wrong-path flush beats everything;
  // push and pop never coincide because a push only happens while the
  // output register is stalled and a pop only while it is draining.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      data_d = din;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Entry storage and occupancy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding the IF/ID register. Owns the word PC,
// issues one instruction-memory request at a time, presents
// {instr, pc_plus_one} to IF/ID under the shared hold stall, and squashes
// wrong-path fetches on redirect.
// Optional feature macro: FETCH_BUBBLE_CNT_EN adds a 32-bit bubble_cnt
// output counting cycles where IF/ID advances while if_valid=0.
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   hold                 - IF/ID stall
//   redirect             - taken branch/jump pulse
//   redirect_target      - new word PC, sampled with redirect
//   imem_req, imem_addr  - memory request strobe and word address
//   imem_rvalid, imem_rdata - memory response strobe and data
//   instr, pc_plus_one   - to IF/ID instrIn / PCPlusOne
//   if_valid             - instr holds a real instruction
//   bubble_cnt           - (FETCH_BUBBLE_CNT_EN only) bubble counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc_plus_one,
  output logic            if_valid
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]     bubble_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            out_valid_q, out_valid_d;
  fetch_entry_t    out_q, out_d;

  logic            resp;
  fetch_entry_t    resp_entry;
  logic            skid_push, skid_pop, skid_flush, skid_full;
  fetch_entry_t    skid_dout;

  // Only a response that arrives while waiting belongs to the current PC;
  // responses seen in S_DRAIN are wrong-path and never reach this entry.
  assign resp       = imem_rvalid && (state_q == S_WAIT);
  assign resp_entry = '{instr: imem_rdata, pc_plus_one: pc_inc(pc_q)};

  fetch_skid_buf u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (skid_push),
    .pop  (skid_pop),
    .flush(skid_flush),
    .din  (resp_entry),
    .dout (skid_dout),
    .full (skid_full)
  );

  // Next-state logic. The output register advances whenever it is empty or
  // IF/ID is not stalled, refilling from the skid buffer first so order is
  // kept. A response that cannot be accepted goes to the skid buffer, and
  // the FSM parks in S_STALL until that entry moves on. Redirect is applied
  // last so it overrides hold and any same-cycle response.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;

    if (!out_valid_q || !hold) begin
      if (skid_full) begin
        out_d       = skid_dout;
        out_valid_d = 1'b1;
        skid_pop    = 1'b1;
      end else if (resp) begin
        out_d       = resp_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_d.instr = NOP_INSTR;
      end
    end else if (resp) begin
      skid_push = 1'b1;
    end

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (resp) begin
          pc_d    = pc_inc(pc_q);
          state_d = skid_push ? S_STALL : S_FETCH;
        end
      end
      S_STALL: if (skid_pop) state_d = S_FETCH;
      S_DRAIN: if (imem_rvalid) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      out_d       = out_q;
      out_d.instr = NOP_INSTR;
      skid_push   = 1'b0;
      skid_pop    = 1'b0;
      skid_flush  = 1'b1;
      case (state_q)
        // The request driven this cycle is still outstanding.
        S_FETCH: state_d = S_DRAIN;
        S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        S_STALL: state_d = S_FETCH;
        default: ;
      endcase
    end

    req_d = (state_d == S_FETCH);
  end

  // All fetch-stage state, including the registered request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '{instr: NOP_INSTR, pc_plus_one: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = out_q.instr;
  assign pc_plus_one = out_q.pc_plus_one;
  assign if_valid    = out_valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // A bubble is a cycle where IF/ID advances but receives no instruction.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!hold && !out_valid_q) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Bubble counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= 32'd0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
